// File: rtl/row_sync_engine_pkg.sv
// Shared definitions for the row synchronisation engine and its MEMSync sibling.
package memsync_pkg;

  localparam int unsigned DEF_CHWIDTH   = 6;
  localparam int unsigned DEF_ADDRWIDTH = 17;
  localparam int unsigned DEF_COLWIDTH  = 3;
  localparam int unsigned DEF_DWIDTH    = 64;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_WR,
    FILL_RD,
    FILL_WR,
    DONE
  } state_t;

endpackage

// File: rtl/row_sync_engine_if.sv
// Request, status, cache-port and memory-port signals of the row sync engine.
interface row_sync_engine_if
  import memsync_pkg::*;
#(
  parameter int unsigned CHWIDTH   = DEF_CHWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned COLWIDTH  = DEF_COLWIDTH,
  parameter int unsigned DWIDTH    = DEF_DWIDTH
) ();

  logic                          req;
  logic                          req_wb;
  logic [CHWIDTH-1:0]            req_cRowId;
  logic [ADDRWIDTH-1:0]          req_RowId;
  logic [ADDRWIDTH-1:0]          req_wbRowId;
  logic                          busy;
  logic                          sync;

  logic [CHWIDTH+COLWIDTH-1:0]   c_addr;
  logic                          c_wr;
  logic [DWIDTH-1:0]             c_wdata;
  logic [DWIDTH-1:0]             c_rdata;

  logic [ADDRWIDTH+COLWIDTH-1:0] m_addr;
  logic                          m_rd;
  logic                          m_wr;
  logic [DWIDTH-1:0]             m_wdata;
  logic [DWIDTH-1:0]             m_rdata;
  logic                          m_ack;

  modport master (
    input  req, req_wb, req_cRowId, req_RowId, req_wbRowId,
    input  c_rdata, m_rdata, m_ack,
    output busy, sync, c_addr, c_wr, c_wdata, m_addr, m_rd, m_wr, m_wdata
  );

  modport slave (
    output req, req_wb, req_cRowId, req_RowId, req_wbRowId,
    output c_rdata, m_rdata, m_ack,
    input  busy, sync, c_addr, c_wr, c_wdata, m_addr, m_rd, m_wr, m_wdata
  );

endinterface

// File: rtl/row_sync_engine_beat_counter.sv
// Beat counter within a row transfer: synchronous clear, increment, last-beat flag.
module row_beat_counter
  import memsync_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_COLWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_beat,
  output logic [WIDTH-1:0] o_beat_next,
  output logic             o_last
);

  logic [WIDTH-1:0] r_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_clr) begin
      r_beat <= '0;
    end else if (i_inc) begin
      r_beat <= r_beat + WIDTH'(1);
    end
  end

  assign o_beat      = r_beat;
  assign o_beat_next = r_beat + WIDTH'(1);
  assign o_last      = &r_beat;

endmodule

// File: rtl/row_sync_engine.sv
// Moves one cache row: optional writeback of the victim row to memory, then a fill
// from memory, one beat at a time, ending with a single-cycle sync pulse.
module row_sync_engine
  import memsync_pkg::*;
#(
  parameter int unsigned CHWIDTH   = DEF_CHWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned COLWIDTH  = DEF_COLWIDTH,
  parameter int unsigned DWIDTH    = DEF_DWIDTH
) (
  input logic               clk,
  input logic               rst,
  row_sync_engine_if.master bus
);

  state_t               r_state;
  logic [CHWIDTH-1:0]   r_slot;
  logic [ADDRWIDTH-1:0] r_row;
  logic [ADDRWIDTH-1:0] r_wbrow;

  logic [COLWIDTH-1:0]  w_beat;
  logic [COLWIDTH-1:0]  w_beat_next;
  logic                 w_last;
  logic                 w_clr;
  logic                 w_inc;
  logic [DWIDTH-1:0]    w_wb_data;

  row_beat_counter #(.WIDTH(COLWIDTH)) u_beat (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_inc       (w_inc),
    .o_beat      (w_beat),
    .o_beat_next (w_beat_next),
    .o_last      (w_last)
  );

  always_comb begin
    w_clr = 1'b0;
    w_inc = 1'b0;
    case (r_state)
      IDLE:    w_clr = bus.req;
      WB_WR:   if (bus.m_ack) begin
                 w_clr = w_last;
                 w_inc = !w_last;
               end
      FILL_WR: w_inc = !w_last;
      default: ;
    endcase
  end

  // Cache read data arrives the cycle after c_addr, so the writeback beat is
  // forwarded straight through instead of costing an extra register stage.
  assign w_wb_data   = bus.c_rdata;
  assign bus.m_wdata = (r_state == WB_WR) ? w_wb_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_row       <= '0;
      r_wbrow     <= '0;
      bus.busy    <= 1'b0;
      bus.sync    <= 1'b0;
      bus.c_addr  <= '0;
      bus.c_wr    <= 1'b0;
      bus.c_wdata <= '0;
      bus.m_addr  <= '0;
      bus.m_rd    <= 1'b0;
      bus.m_wr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req) begin
          r_slot   <= bus.req_cRowId;
          r_row    <= bus.req_RowId;
          r_wbrow  <= bus.req_wbRowId;
          bus.busy <= 1'b1;
          if (bus.req_wb) begin
            r_state    <= WB_RD;
            bus.c_addr <= {bus.req_cRowId, {COLWIDTH{1'b0}}};
          end else begin
            r_state    <= FILL_RD;
            bus.m_rd   <= 1'b1;
            bus.m_addr <= {bus.req_RowId, {COLWIDTH{1'b0}}};
          end
        end
        WB_RD: begin
          r_state    <= WB_WR;
          bus.m_wr   <= 1'b1;
          bus.m_addr <= {r_wbrow, w_beat};
        end
        WB_WR: if (bus.m_ack) begin
          bus.m_wr <= 1'b0;
          if (w_last) begin
            r_state    <= FILL_RD;
            bus.m_rd   <= 1'b1;
            bus.m_addr <= {r_row, {COLWIDTH{1'b0}}};
          end else begin
            r_state    <= WB_RD;
            bus.c_addr <= {r_slot, w_beat_next};
          end
        end
        FILL_RD: if (bus.m_ack) begin
          r_state     <= FILL_WR;
          bus.m_rd    <= 1'b0;
          bus.c_wr    <= 1'b1;
          bus.c_addr  <= {r_slot, w_beat};
          bus.c_wdata <= bus.m_rdata;
        end
        FILL_WR: begin
          bus.c_wr <= 1'b0;
          if (w_last) begin
            r_state  <= DONE;
            bus.sync <= 1'b1;
          end else begin
            r_state    <= FILL_RD;
            bus.m_rd   <= 1'b1;
            bus.m_addr <= {r_row, w_beat_next};
          end
        end
        DONE: begin
          r_state  <= IDLE;
          bus.sync <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
